// File: rtl/tmds_channel_decoder.sv
// Receive-side TMDS channel decoder: finds word alignment from control-token
// bursts, then decodes each aligned 10-bit symbol into pixel or control data.
module tmds_channel_decoder #(
    parameter int SEARCH_WINDOW = 4096,
    parameter int MIN_RUN       = 8
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] din,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int TW = $clog2(SEARCH_WINDOW);

    typedef enum logic {
        SEARCH,
        LOCKED
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  din_q, din_d;
    logic [9:0]  sym_q, sym_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [1:0]  ctrl_out_q, ctrl_out_d;
    logic        de_out_q, de_out_d;
    logic        locked_q, locked_d;
    logic [3:0]  offset_q, offset_d;
    logic [7:0]  run_q, run_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]  skip_q, skip_d;

    logic [19:0] window;
    logic        hit;
    logic [1:0]  tok_ctrl;
    logic [7:0]  d;
    logic [7:0]  dec;
    logic        skip;
    logic        burst;
    logic        expire;
    logic        slip;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= SEARCH;
            din_q      <= '0;
            sym_q      <= '0;
            data_out_q <= '0;
            ctrl_out_q <= '0;
            de_out_q   <= 1'b0;
            locked_q   <= 1'b0;
            offset_q   <= '0;
            run_q      <= '0;
            timer_q    <= '0;
            skip_q     <= '0;
        end else begin
            state_q    <= state_d;
            din_q      <= din_d;
            sym_q      <= sym_d;
            data_out_q <= data_out_d;
            ctrl_out_q <= ctrl_out_d;
            de_out_q   <= de_out_d;
            locked_q   <= locked_d;
            offset_q   <= offset_d;
            run_q      <= run_d;
            timer_q    <= timer_d;
            skip_q     <= skip_d;
        end
    end

    always_comb begin
        window = {din, din_q};
        din_d  = din;
        sym_d  = 10'(window >> offset_q);

        hit      = 1'b1;
        tok_ctrl = 2'b00;
        case (sym_q)
            10'h354: tok_ctrl = 2'b00;
            10'h0AB: tok_ctrl = 2'b01;
            10'h154: tok_ctrl = 2'b10;
            10'h2AB: tok_ctrl = 2'b11;
            default: hit = 1'b0;
        endcase

        d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec    = '0;
        dec[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end

        if (hit) begin
            de_out_d   = 1'b0;
            ctrl_out_d = tok_ctrl;
            data_out_d = '0;
        end else begin
            de_out_d   = locked_q;
            ctrl_out_d = ctrl_out_q;
            data_out_d = dec;
        end

        // A burst landing on the expiry cycle takes priority over slipping.
        skip   = (skip_q != 2'd0);
        burst  = hit && !skip && (run_q == 8'(MIN_RUN - 1));
        expire = (timer_q == TW'(SEARCH_WINDOW - 1));

        state_d  = state_q;
        locked_d = locked_q;
        slip     = 1'b0;
        case (state_q)
            SEARCH: begin
                if (burst) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else if (expire) begin
                    slip = 1'b1;
                end
            end
            LOCKED: begin
                if (!burst && expire) begin
                    state_d  = SEARCH;
                    locked_d = 1'b0;
                    slip     = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        offset_d = offset_q;
        if (slip) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        end

        if (skip || slip) begin
            run_d = '0;
        end else if (hit) begin
            run_d = (run_q == 8'(MIN_RUN)) ? run_q : run_q + 8'd1;
        end else begin
            run_d = '0;
        end

        if (burst || slip || (state_d != state_q)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        // The two words already in the pipeline after a slip were cut at the old offset.
        if (slip) begin
            skip_d = 2'd2;
        end else if (skip) begin
            skip_d = skip_q - 2'd1;
        end else begin
            skip_d = 2'd0;
        end
    end

    assign data_out = data_out_q;
    assign ctrl_out = ctrl_out_q;
    assign de_out   = de_out_q;
    assign locked   = locked_q;
    assign offset   = offset_q;

endmodule
